// File: rtl/bcd_mod_counter.sv
// Multi-digit BCD modulo counter with registered carry/borrow and range-checked load.
// Define BCD_CNT_DOWN_EN to add up/down counting selected by up_dn; otherwise up-only.
module bcd_mod_counter #(
  parameter int DIGITS  = 2,
  parameter int MODULUS = 60
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                up_dn,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] q,
  output logic                carry,
  output logic                load_err
);

  localparam int W = 4 * DIGITS;

  function automatic logic [W-1:0] to_bcd(input int value);
    logic [W-1:0] result;
    int           rest;
    result = '0;
    rest   = value;
    for (int i = 0; i < DIGITS; i++) begin
      result[4*i +: 4] = 4'(rest % 10);
      rest             = rest / 10;
    end
    return result;
  endfunction

  localparam logic [W-1:0] MAX_BCD = to_bcd(MODULUS - 1);

  logic [W-1:0] inc_val;
  logic         inc_ripple;
  logic         digits_ok;
  logic         load_ok;

  // With every digit <= 9, BCD vectors order the same as their decimal values.
  always_comb begin
    digits_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) digits_ok = 1'b0;
    end
    load_ok = digits_ok && (load_val <= MAX_BCD);
  end

  always_comb begin
    inc_val    = q;
    inc_ripple = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (inc_ripple) begin
        if (q[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = q[4*i +: 4] + 4'd1;
          inc_ripple        = 1'b0;
        end
      end
    end
  end

`ifdef BCD_CNT_DOWN_EN
  logic [W-1:0] dec_val;
  logic         dec_ripple;

  always_comb begin
    dec_val    = q;
    dec_ripple = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (dec_ripple) begin
        if (q[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = q[4*i +: 4] - 4'd1;
          dec_ripple        = 1'b0;
        end
      end
    end
  end
`else
  logic unused_up_dn;
  assign unused_up_dn = up_dn;
`endif

  // Priority: rst > load > en > hold; carry and load_err default low every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      q        <= '0;
      carry    <= 1'b0;
      load_err <= 1'b0;
    end else begin
      carry    <= 1'b0;
      load_err <= 1'b0;
      if (load) begin
        if (load_ok) q <= load_val;
        else         load_err <= 1'b1;
      end else if (en) begin
`ifdef BCD_CNT_DOWN_EN
        if (!up_dn) begin
          if (q == '0) begin
            q     <= MAX_BCD;
            carry <= 1'b1;
          end else begin
            q <= dec_val;
          end
        end else
`endif
        if (q == MAX_BCD) begin
          q     <= '0;
          carry <= 1'b1;
        end else begin
          q <= inc_val;
        end
      end
    end
  end

endmodule
